// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first.
// A request accepted in IDLE takes WIDTH RUN cycles, then a one-cycle DONE pulse.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic [WIDTH-1:0] r_d;
   logic             r_bo;

   logic             w_x;
   logic             w_y;
   logic             w_diff;
   logic             w_borrow_next;
   logic             w_last;

   assign w_x           = r_ra[0];
   assign w_y           = r_rb[0];
   assign w_diff        = w_x ^ w_y ^ r_borrow;
   assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
   assign w_last        = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ra     <= '0;
         r_rb     <= '0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_d      <= '0;
         r_bo     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_ra     <= a;
                  r_rb     <= b;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               // Difference bits enter at the MSB so the first bit ends up at bit 0.
               r_res    <= {w_diff, r_res[WIDTH-1:1]};
               r_borrow <= w_borrow_next;
               r_ra     <= r_ra >> 1;
               r_rb     <= r_rb >> 1;
               if (w_last) begin
                  r_cnt <= '0;
                  r_d   <= {w_diff, r_res[WIDTH-1:1]};
                  r_bo  <= w_borrow_next;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
   assign d    = r_d;
   assign bo   = r_bo;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): hand-computed differences,
// ignored starts, mid-run reset and back-to-back issue.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bo;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_accept = 0;
   int prev_accept = 0;
   logic [WIDTH-1:0] hold_d  = '0;
   logic             hold_bo = 1'b0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bo    (bo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Full operation. Starts from an IDLE cycle, ends one cycle after DONE.
   // inject_at >= 0 pulses a competing start during that RUN cycle.
   task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] ed, input logic ebo, input int inject_at);
      a = va; b = vb; start = 1'b1;
      tick();
      prev_accept = last_accept;
      last_accept = cyc;
      start = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         a = ~va; b = va ^ vb;
         start = (i == inject_at);
         if (i == inject_at) begin a = 8'hFF; b = 8'h00; end
         check($sformatf("busy_run%0d", i), busy, 1);
         check($sformatf("done_run%0d", i), done, 0);
         check($sformatf("hold_d_run%0d", i), d, hold_d);
         check($sformatf("hold_bo_run%0d", i), bo, hold_bo);
         tick();
      end
      start = 1'b0;
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 0);
      check("d_result", d, ed);
      check("bo_result", bo, ebo);
      $display("op %02h - %02h -> d=%02h bo=%0b (exp %02h %0b)", va, vb, d, bo, ed, ebo);
      hold_d = ed; hold_bo = ebo;
      tick();
      check("done_one_cycle", done, 0);
      check("busy_after", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_d", d, 0);
      check("rst_bo", bo, 0);

      // start held during reset is ignored
      start = 1'b1; a = 8'h12; b = 8'h34;
      tick();
      check("rst_start_busy", busy, 0);
      start = 1'b0; rst_n = 1'b1;
      tick();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);

      run_op(8'h05, 8'h03, 8'h02, 1'b0, -1);
      run_op(8'h03, 8'h05, 8'hFE, 1'b1, -1);
      run_op(8'h00, 8'hFF, 8'h01, 1'b1, -1);
      run_op(8'h00, 8'h00, 8'h00, 1'b0, -1);
      run_op(8'hFF, 8'h01, 8'hFE, 1'b0, -1);
      run_op(8'h80, 8'h80, 8'h00, 1'b0, -1);

      // competing start at RUN cycle 3 must be dropped
      run_op(8'h05, 8'h03, 8'h02, 1'b0, 2);
      for (int i = 0; i < WIDTH + 2; i++) begin
         check($sformatf("dropped_busy%0d", i), busy, 0);
         check($sformatf("dropped_done%0d", i), done, 0);
         tick();
      end

      // reset at RUN cycle 4 aborts without a done pulse
      a = 8'h05; b = 8'h03; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("abort_busy%0d", i), busy, 1);
         tick();
      end
      rst_n = 1'b0;
      tick();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_d", d, 0);
      check("abort_bo", bo, 0);
      rst_n = 1'b1;
      hold_d = '0; hold_bo = 1'b0;
      for (int i = 0; i < WIDTH + 2; i++) begin
         check($sformatf("abort_nodone%0d", i), done, 0);
         tick();
      end
      run_op(8'h10, 8'h01, 8'h0F, 1'b0, -1);

      // back-to-back: second start in the IDLE cycle right after DONE
      run_op(8'h05, 8'h03, 8'h02, 1'b0, -1);
      run_op(8'h0A, 8'h0B, 8'hFF, 1'b1, -1);
      check("b2b_interval", last_accept - prev_accept, WIDTH + 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
